sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one sram-like memory port between the fetch stage (instruction master) and the memory stage (data master).
- Uses the codebase req/addr_ok/data_ok handshake on all three ports.
- At most one transaction outstanding; data master has priority, with an anti-starvation counter protecting fetch.
- Supports cancelling an in-flight fetch on exception/eret flush, so the stale instruction never reaches the fetch stage.

Parameters:
STARVE_MAX, 4, consecutive lost-arbitration cycles after which a waiting inst_req overrides data priority (>=1)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  ADDR_W  fetch address
inst_cancel  in  1  flush: drop response of in-flight/just-accepted fetch
inst_addr_ok  out  1  fetch address accepted
inst_data_ok  out  1  fetch data valid
inst_rdata  out  DATA_W  fetch data
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1 = write
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  write data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  read data valid / write complete
data_rdata  out  DATA_W  read data
mem_req  out  1  request to memory
mem_wr  out  1  write flag
mem_size  out  2  size
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_addr_ok  in  1  memory accepted address
mem_data_ok  in  1  memory response
mem_rdata  in  DATA_W  memory read data
busy  out  1  transaction outstanding

Behaviour:
- States: IDLE, OUT_I (inst outstanding), OUT_D (data outstanding). Reset (reset==0 at clk edge): state=IDLE, lock=0, cancel_flag=0, starve_cnt=0.
- Outputs while reset==0: all *_addr_ok, *_data_ok, mem_req, busy = 0.
- IDLE grant, combinational, unless lock set:
  - inst, if inst_req && (!data_req || starve_cnt==STARVE_MAX);
  - else data, if data_req;
  - else none.
- Lock: if mem_req=1 and mem_addr_ok=0, the grant is registered and held next cycle.
  - Lock is released on acceptance, or if the locked master drops its req (mem_req then 0 that cycle; re-arbitrate next cycle).
- mem_* fields mux from the grant.
  - Inst grant: mem_wr=0, mem_size=2, mem_wdata=0.
  - No grant: mem_req=0, other mem_* = 0.
- Acceptance: mem_req && mem_addr_ok. The granted master's addr_ok = mem_addr_ok in the same cycle (combinational); the other master's addr_ok = 0. Next state = OUT_I or OUT_D.
- OUT_x: mem_req=0, both addr_ok=0, busy=1.
  - On mem_data_ok: owner's data_ok=1 the same cycle; x_rdata = mem_rdata pass-through. Next state = IDLE.
  - A new request is issued only from IDLE, giving one bubble cycle minimum.
- data_data_ok asserts for writes too. Non-owner data_ok is always 0. rdata outputs may show mem_rdata whenever data_ok is 0.
- mem_data_ok in IDLE (stray, e.g. after reset mid-transaction) is ignored; no data_ok forwarded.
- starve_cnt: width clog2(STARVE_MAX+1), saturating.
  - +1 each IDLE cycle with inst_req=1 and inst not granted.
  - Cleared on inst acceptance or when inst_req=0. Held in OUT_x.
- Cancel:
  - inst_cancel=1 while state=OUT_I, or in the cycle of inst acceptance, sets cancel_flag.
  - While cancel_flag=1, the matching mem_data_ok is consumed: inst_data_ok=0, state → IDLE, flag cleared.
  - inst_cancel in IDLE without acceptance, or in OUT_D, has no effect.
  - inst_cancel in the same cycle as mem_data_ok in OUT_I suppresses that inst_data_ok.
- Simultaneous inst_req and data_req with starve_cnt<STARVE_MAX: data wins. Equal-cycle addr_ok to both is impossible.

Decomposition:
- Shared package: state encoding (ARB_IDLE/ARB_OUT_I/ARB_OUT_D), owner enum (OWN_NONE/OWN_INST/OWN_DATA), size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- Single module, no sub-module; grant mux and starve counter are small enough to inline.

Test Plan:
- Inst only: inst_req=1, addr=0xBFC00000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata=0x24080001 -> inst_addr_ok=1 at accept, mem_wr=0, mem_size=2, inst_data_ok=1 with inst_rdata=0x24080001, data_* silent.
- Contention: inst_req and data_req (wr=1, size=0, addr=0x80000004, wdata=0xAB) both high in IDLE -> data granted first; inst granted after data_data_ok plus one bubble.
- Starvation: data_req held high continuously, STARVE_MAX=4 -> inst wins arbitration on the 5th IDLE cycle of waiting; starve_cnt returns to 0.
- Lock: data grant with mem_addr_ok=0 for 3 cycles while inst_req rises -> mem_addr/mem_wr stay on data throughout; inst not granted until data completes.
- Cancel: inst accepted, inst_cancel pulse in OUT_I, then mem_data_ok -> inst_data_ok stays 0, state IDLE; next fetch to 0x80000000 completes normally.
- Reset mid-op: reset=0 for one cycle in OUT_D, then stray mem_data_ok -> data_data_ok=0, busy=0, mem_req=0 while reset=0.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the sram-like bus arbiter: FSM states, grant owner
// and the transfer size codes carried on the *_size fields.
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OUT_I = 2'd1,
    ARB_OUT_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Bundle of the three req/addr_ok/data_ok ports around the arbiter:
// fetch (inst_*), memory stage (data_*) and the shared memory (mem_*).
// The slave modport is the arbiter's view; the master modport is the
// surrounding pipeline plus memory that drives and consumes it.
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_cancel;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter in front of one sram-like memory port. One transaction
// may be outstanding at a time. The data master normally wins, but a fetch
// that has lost STARVE_MAX consecutive idle cycles overrides it. A grant the
// memory has not yet accepted is locked so the request stays stable, and an
// in-flight fetch can be cancelled so its stale response is swallowed.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  sram_bus_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Saturating increment for the starvation counter.
  function automatic logic [CNT_W-1:0] starve_sat_inc(input logic [CNT_W-1:0] c);
    if (c == STARVE_LIM) return c;
    return c + CNT_W'(1);
  endfunction

  arb_state_e       state_q, state_d;
  logic             lock_q, lock_d;
  owner_e           lock_own_q, lock_own_d;
  logic             cancel_q, cancel_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  owner_e            grant;
  logic              accept;
  logic              mem_req_c;
  logic              mem_wr_c;
  logic [1:0]        mem_size_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // Pick the master that drives the memory port this cycle (idle only).
  always_comb begin
    grant = OWN_NONE;
    if (reset && state_q == ARB_IDLE) begin
      if (lock_q) begin
        // A locked master keeps the port until accepted or it withdraws.
        if (lock_own_q == OWN_INST && bus.inst_req)
          grant = OWN_INST;
        else if (lock_own_q == OWN_DATA && bus.data_req)
          grant = OWN_DATA;
      end else if (bus.inst_req && (!bus.data_req || starve_q == STARVE_LIM)) begin
        grant = OWN_INST;
      end else if (bus.data_req) begin
        grant = OWN_DATA;
      end
    end
  end

  // Steer the granted master's request fields onto the memory port.
  always_comb begin
    mem_req_c   = 1'b0;
    mem_wr_c    = 1'b0;
    mem_size_c  = 2'd0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (grant)
      OWN_INST: begin
        mem_req_c  = 1'b1;
        mem_size_c = SZ_WORD;
        mem_addr_c = bus.inst_addr;
      end
      OWN_DATA: begin
        mem_req_c   = 1'b1;
        mem_wr_c    = bus.data_wr;
        mem_size_c  = bus.data_size;
        mem_addr_c  = bus.data_addr;
        mem_wdata_c = bus.data_wdata;
      end
      default: ;
    endcase
  end

  assign accept        = mem_req_c && bus.mem_addr_ok;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_size  = mem_size_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  // Handshake returns: addr_ok follows memory acceptance for the grantee,
  // data_ok goes to the owner of the outstanding transaction. A cancelled
  // fetch (flag set earlier or cancel in this very cycle) gets no data_ok.
  assign bus.inst_addr_ok = (grant == OWN_INST) && bus.mem_addr_ok;
  assign bus.data_addr_ok = (grant == OWN_DATA) && bus.mem_addr_ok;
  assign bus.inst_data_ok = reset && (state_q == ARB_OUT_I) && bus.mem_data_ok &&
                            !cancel_q && !bus.inst_cancel;
  assign bus.data_data_ok = reset && (state_q == ARB_OUT_D) && bus.mem_data_ok;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;
  assign busy             = reset && (state_q != ARB_IDLE);

  // Next-state for FSM, grant lock, cancel flag and starvation counter.
  always_comb begin
    state_d    = state_q;
    lock_d     = 1'b0;
    lock_own_d = OWN_NONE;
    cancel_d   = cancel_q;
    starve_d   = starve_q;
    case (state_q)
      ARB_IDLE: begin
        cancel_d = 1'b0;
        if (accept) begin
          state_d  = (grant == OWN_INST) ? ARB_OUT_I : ARB_OUT_D;
          cancel_d = (grant == OWN_INST) && bus.inst_cancel;
        end else if (mem_req_c) begin
          lock_d     = 1'b1;
          lock_own_d = grant;
        end
        if (!bus.inst_req)
          starve_d = '0;
        else if (grant != OWN_INST)
          starve_d = starve_sat_inc(starve_q);
        else if (accept)
          starve_d = '0;
      end
      ARB_OUT_I: begin
        if (bus.inst_cancel)
          cancel_d = 1'b1;
        if (bus.mem_data_ok) begin
          state_d  = ARB_IDLE;
          cancel_d = 1'b0;
        end
      end
      ARB_OUT_D: begin
        if (bus.mem_data_ok)
          state_d = ARB_IDLE;
      end
      default: begin
        state_d  = ARB_IDLE;
        cancel_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      lock_q     <= 1'b0;
      lock_own_q <= OWN_NONE;
      cancel_q   <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      cancel_q   <= cancel_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter. Stimulus pushes the expected
// handshake events into a queue; a negedge monitor pops one entry for every
// addr_ok/data_ok it sees and compares the presented fields.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  localparam int K_IADDR = 0;
  localparam int K_DADDR = 1;
  localparam int K_IDATA = 2;
  localparam int K_DDATA = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic        w;
    logic [1:0]  s;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic reset;
  logic busy;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_bus_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_IADDR: return "inst_addr_ok";
      K_DADDR: return "data_addr_ok";
      K_IDATA: return "inst_data_ok";
      default: return "data_data_ok";
    endcase
  endfunction

  task automatic exp_addr(input int k, input logic [31:0] a, input logic w,
                          input logic [1:0] s, input logic [31:0] d);
    exp_t e;
    e.kind = k; e.a = a; e.w = w; e.s = s; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_data(input int k, input logic [31:0] d);
    exp_addr(k, 32'h0, 1'b0, 2'd0, d);
  endtask

  task automatic mon_check(input int k, input logic [31:0] a, input logic w,
                           input logic [1:0] s, input logic [31:0] d);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected at %0t: got a=%h w=%0d s=%0d d=%h, required no event",
               kname(k), $time, a, w, s, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.w !== w || e.s !== s || e.d !== d) begin
        n_fail++;
        $display("FAIL %s at %0t: got a=%h w=%0d s=%0d d=%h, required %s a=%h w=%0d s=%0d d=%h",
                 kname(k), $time, a, w, s, d, kname(e.kind), e.a, e.w, e.s, e.d);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'h0;
    bus.inst_cancel = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_size   = SZ_WORD;
    bus.data_addr   = 32'h0;
    bus.data_wdata  = 32'h0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
  endtask

  // Scoreboard monitor: one queue entry per handshake pulse.
  always @(negedge clk) begin
    if (bus.inst_addr_ok)
      mon_check(K_IADDR, bus.mem_addr, bus.mem_wr, bus.mem_size, bus.mem_wdata);
    if (bus.data_addr_ok)
      mon_check(K_DADDR, bus.mem_addr, bus.mem_wr, bus.mem_size, bus.mem_wdata);
    if (bus.inst_data_ok)
      mon_check(K_IDATA, 32'h0, 1'b0, 2'd0, bus.inst_rdata);
    if (bus.data_data_ok)
      mon_check(K_DDATA, 32'h0, 1'b0, 2'd0, bus.data_rdata);
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    reset = 1'b0;
    // Reset held with every request asserted: nothing may leak out.
    bus.inst_req    = 1'b1;
    bus.data_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    bus.mem_data_ok = 1'b1;
    cyc(); cyc();
    #2;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("reset_addr_ok", {30'h0, bus.inst_addr_ok, bus.data_addr_ok}, 32'h0);
    clear_inputs();
    cyc();
    reset = 1'b1;
    cyc();

    // Inst only.
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0000; bus.mem_addr_ok = 1'b1;
    exp_addr(K_IADDR, 32'hBFC0_0000, 1'b0, SZ_WORD, 32'h0);
    #2 chk("t1_mem_req", {31'h0, bus.mem_req}, 32'h1);
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    #2 chk("t1_busy", {31'h0, busy}, 32'h1);
    chk("t1_no_reissue", {31'h0, bus.mem_req}, 32'h0);
    cyc();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h2408_0001;
    exp_data(K_IDATA, 32'h2408_0001);
    cyc();
    bus.mem_data_ok = 1'b0;
    #2 chk("t1_idle_busy", {31'h0, busy}, 32'h0);
    cyc();

    // Contention: data wins, inst follows after the response.
    bus.inst_req = 1'b1; bus.inst_addr = 32'h8000_0100;
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = SZ_BYTE;
    bus.data_addr = 32'h8000_0004; bus.data_wdata = 32'h0000_00AB;
    bus.mem_addr_ok = 1'b1;
    exp_addr(K_DADDR, 32'h8000_0004, 1'b1, SZ_BYTE, 32'h0000_00AB);
    cyc();
    bus.data_req = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0;
    exp_data(K_DDATA, 32'h0);
    #2 chk("t2_out_no_req", {31'h0, bus.mem_req}, 32'h0);
    cyc();
    bus.mem_data_ok = 1'b0;
    exp_addr(K_IADDR, 32'h8000_0100, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.inst_req = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1111_2222;
    exp_data(K_IDATA, 32'h1111_2222);
    cyc();
    clear_inputs();
    cyc();

    // Starvation: data wins four idle cycles, inst takes the fifth.
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_2000;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = SZ_WORD;
    bus.mem_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_data_ok = 1'b0;
      bus.data_addr = 32'h0000_1000 + 32'(k * 4);
      exp_addr(K_DADDR, 32'h0000_1000 + 32'(k * 4), 1'b0, SZ_WORD, 32'h0);
      cyc();
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'(k + 1);
      exp_data(K_DDATA, 32'(k + 1));
      cyc();
    end
    bus.mem_data_ok = 1'b0;
    exp_addr(K_IADDR, 32'h0000_2000, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.inst_req = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hCAFE_0000;
    exp_data(K_IDATA, 32'hCAFE_0000);
    #2 chk("t3_starve_clear", 32'(dut.starve_q), 32'h0);
    cyc();
    clear_inputs();
    cyc();

    // Lock: unaccepted data grant stays on the port while inst waits long
    // enough that it would otherwise win on starvation.
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = SZ_HALF;
    bus.data_addr = 32'h0000_3000; bus.data_wdata = 32'h0000_5A5A;
    for (int c = 0; c < 6; c++) begin
      #2 chk("t4_lock_addr", bus.mem_addr, 32'h0000_3000);
      chk("t4_lock_wr_size", {29'h0, bus.mem_wr, bus.mem_size}, {29'h0, 1'b1, SZ_HALF});
      cyc();
      bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_4000;
    end
    bus.mem_addr_ok = 1'b1;
    exp_addr(K_DADDR, 32'h0000_3000, 1'b1, SZ_HALF, 32'h0000_5A5A);
    cyc();
    bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0;
    exp_data(K_DDATA, 32'h0);
    cyc();
    bus.mem_data_ok = 1'b0; bus.mem_addr_ok = 1'b1;
    exp_addr(K_IADDR, 32'h0000_4000, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h4444_0000;
    exp_data(K_IDATA, 32'h4444_0000);
    cyc();
    clear_inputs();
    cyc();

    // Cancel pulse while the fetch is outstanding.
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_5000; bus.mem_addr_ok = 1'b1;
    exp_addr(K_IADDR, 32'h0000_5000, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.inst_cancel = 1'b1;
    cyc();
    bus.inst_cancel = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    #2 chk("t5_cancel_dok", {31'h0, bus.inst_data_ok}, 32'h0);
    cyc();
    bus.mem_data_ok = 1'b0;
    #2 chk("t5_cancel_idle", {31'h0, busy}, 32'h0);
    bus.inst_req = 1'b1; bus.inst_addr = 32'h8000_0000; bus.mem_addr_ok = 1'b1;
    exp_addr(K_IADDR, 32'h8000_0000, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h3C1D_8000;
    exp_data(K_IDATA, 32'h3C1D_8000);
    cyc();
    bus.mem_data_ok = 1'b0;

    // Cancel in the cycle of acceptance.
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_5100; bus.mem_addr_ok = 1'b1;
    bus.inst_cancel = 1'b1;
    exp_addr(K_IADDR, 32'h0000_5100, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.inst_cancel = 1'b0;
    cyc();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0BAD_0001;
    cyc();
    bus.mem_data_ok = 1'b0;

    // Cancel in idle is ignored; cancel coinciding with the response drops it.
    bus.inst_cancel = 1'b1;
    cyc();
    bus.inst_cancel = 1'b0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_5200; bus.mem_addr_ok = 1'b1;
    exp_addr(K_IADDR, 32'h0000_5200, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1234_5678;
    exp_data(K_IDATA, 32'h1234_5678);
    cyc();
    bus.mem_data_ok = 1'b0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_5300; bus.mem_addr_ok = 1'b1;
    exp_addr(K_IADDR, 32'h0000_5300, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    bus.inst_cancel = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0BAD_0002;
    #2 chk("t5_same_cycle_cancel", {31'h0, bus.inst_data_ok}, 32'h0);
    cyc();
    clear_inputs();
    cyc();

    // Reset while a data read is outstanding, then a stray response.
    bus.data_req = 1'b1; bus.data_addr = 32'h0000_6000; bus.mem_addr_ok = 1'b1;
    exp_addr(K_DADDR, 32'h0000_6000, 1'b0, SZ_WORD, 32'h0);
    cyc();
    bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0;
    reset = 1'b0;
    #2 chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    chk("t6_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    cyc();
    reset = 1'b1;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h6666_6666;
    #2 chk("t6_stray_dok", {31'h0, bus.data_data_ok}, 32'h0);
    chk("t6_stray_busy", {31'h0, busy}, 32'h0);
    chk("t6_stray_mem_req", {31'h0, bus.mem_req}, 32'h0);
    cyc();
    clear_inputs();
    cyc(); cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
